chroma_pair_scheduler: RTL and testbench

Sequences the background and foreground 128-bit pixel FIFOs in lockstep and turns them into a single chroma-keyed 24-bit pixel stream for the pixel feeder / DVI path. Each FIFO word holds 4 packed 32-bit pixels. The block reads one bg word and one fg word together, then unpacks both. It selects bg wherever the fg pixel matches the green key, and emits the result over a ready/valid interface. It also tracks raster position, so downstream logic gets frame and line markers.

---
 rtl/chroma_pair_scheduler.sv | 136 +++++++++++++
 tb/tb_chroma_pair_scheduler.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chroma_pair_scheduler.sv
// Reads bg/fg 128-bit FIFO words in lockstep, unpacks 4 pixels per word and
// emits a green-keyed composite stream with raster frame/line markers.
module chroma_pair_scheduler #(
  parameter int         FRAME_W   = 800,
  parameter int         FRAME_H   = 600,
  parameter logic [7:0] KEY_G_MIN = 8'd150,
  parameter logic [7:0] KEY_R_MAX = 8'd100,
  parameter logic [7:0] KEY_B_MAX = 8'd100
) (
  input  logic         clockgoing_pin,
  input  logic         aresetn,
  input  logic         enable,
  input  logic [127:0] bg_dout,
  input  logic         bg_empty,
  output logic         bg_rd_en,
  input  logic [127:0] fg_dout,
  input  logic         fg_empty,
  output logic         fg_rd_en,
  output logic [23:0]  video,
  output logic         video_valid,
  input  logic         video_ready,
  output logic         frame_start,
  output logic         line_end,
  output logic [15:0]  skew_cnt,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    EMIT  = 2'd3
  } state_t;

  localparam int XW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int YW = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;

  state_t         state_q, state_d;
  logic [127:0]   bg_word, fg_word;
  logic [1:0]     lane, lane_n;
  logic [XW-1:0]  x, x_next;
  logic [YW-1:0]  y, y_next;
  logic           accept, last_x;
  logic [23:0]    next_px;

  // Key test runs on the fg lane; keyed pixels show the bg lane instead.
  function automatic logic [23:0] composite(input logic [31:0] bg_px,
                                            input logic [31:0] fg_px);
    logic key;
    key = (fg_px[15:8] >= KEY_G_MIN) && (fg_px[23:16] <= KEY_R_MAX) &&
          (fg_px[7:0] <= KEY_B_MAX);
    return key ? bg_px[23:0] : fg_px[23:0];
  endfunction

  assign accept  = video_valid & video_ready;
  assign last_x  = (x == XW'(FRAME_W - 1));
  assign lane_n  = lane + 2'd1;
  assign next_px = composite(bg_word[{lane_n, 5'd0} +: 32],
                             fg_word[{lane_n, 5'd0} +: 32]);
  assign state   = state_q;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    x_next = last_x ? '0 : x + 1'b1;
    y_next = y;
    if (last_x) y_next = (y == YW'(FRAME_H - 1)) ? '0 : y + 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    bg_rd_en = 1'b0;
    fg_rd_en = 1'b0;
    case (state_q)
      IDLE:  if (enable && !bg_empty && !fg_empty) state_d = FETCH;
      FETCH: begin
        bg_rd_en = 1'b1;
        fg_rd_en = 1'b1;
        state_d  = LOAD;
      end
      LOAD:  state_d = EMIT;
      EMIT:  if (accept && lane == 2'd3) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clockgoing_pin) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clockgoing_pin) begin
    if (!aresetn) begin
      // NOTE: the latched words are reset too, so a mid-frame reset leaves no stale pixels behind.
      bg_word     <= '0;
      fg_word     <= '0;
      video       <= '0;
      video_valid <= 1'b0;
      frame_start <= 1'b0;
      line_end    <= 1'b0;
      lane        <= '0;
      x           <= '0;
      y           <= '0;
      skew_cnt    <= '0;
    end else begin
      if (state_q == IDLE && enable && (bg_empty ^ fg_empty) && skew_cnt != 16'hFFFF)
        skew_cnt <= skew_cnt + 16'd1;

      if (state_q == LOAD) begin
        bg_word     <= bg_dout;
        fg_word     <= fg_dout;
        video       <= composite(bg_dout[31:0], fg_dout[31:0]);
        video_valid <= 1'b1;
        lane        <= '0;
        frame_start <= (x == '0) && (y == '0);
        line_end    <= last_x;
      end

      if (state_q == EMIT && accept) begin
        x <= x_next;
        y <= y_next;
        if (lane != 2'd3) begin
          lane        <= lane_n;
          video       <= next_px;
          frame_start <= (x_next == '0) && (y_next == '0);
          line_end    <= (x_next == XW'(FRAME_W - 1));
        end else begin
          video_valid <= 1'b0;
          frame_start <= 1'b0;
          line_end    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_chroma_pair_scheduler.sv
// Self-checking bench: FIFO pair model, keyed-pixel reference queue and raster
// marker model derived from the accepted pixel count.
module tb_chroma_pair_scheduler;

  localparam int W = 8;
  localparam int H = 2;

  logic         clockgoing_pin = 1'b0;
  logic         aresetn, enable, video_ready;
  logic [127:0] bg_dout = '0, fg_dout = '0;
  logic         bg_empty, fg_empty, bg_rd_en, fg_rd_en;
  logic [23:0]  video;
  logic         video_valid, frame_start, line_end;
  logic [15:0]  skew_cnt;
  logic [1:0]   state;

  int checks = 0;
  int errors = 0;

  logic [127:0] bg_mem [256];
  logic [127:0] fg_mem [256];
  int bg_wr = 0, bg_rd = 0, fg_wr = 0, fg_rd = 0;
  logic [23:0] exp_q [$];
  int pix_cnt = 0;
  logic prev_rd = 1'b0;

  always #5 clockgoing_pin = ~clockgoing_pin;

  chroma_pair_scheduler #(.FRAME_W(W), .FRAME_H(H)) dut (
    .clockgoing_pin(clockgoing_pin),
    .aresetn(aresetn),
    .enable(enable),
    .bg_dout(bg_dout),
    .bg_empty(bg_empty),
    .bg_rd_en(bg_rd_en),
    .fg_dout(fg_dout),
    .fg_empty(fg_empty),
    .fg_rd_en(fg_rd_en),
    .video(video),
    .video_valid(video_valid),
    .video_ready(video_ready),
    .frame_start(frame_start),
    .line_end(line_end),
    .skew_cnt(skew_cnt),
    .state(state)
  );

  // Standard (non-FWFT) FIFO model: data appears the cycle after rd_en.
  assign bg_empty = (bg_wr == bg_rd);
  assign fg_empty = (fg_wr == fg_rd);

  always @(posedge clockgoing_pin) begin
    if (bg_rd_en) begin
      bg_dout <= bg_mem[bg_rd % 256];
      bg_rd   <= bg_rd + 1;
    end
    if (fg_rd_en) begin
      fg_dout <= fg_mem[fg_rd % 256];
      fg_rd   <= fg_rd + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] model_px(input logic [31:0] b, input logic [31:0] f);
    int r, g, bl;
    r  = (f >> 16) & 255;
    g  = (f >> 8) & 255;
    bl = f & 255;
    if (g >= 150 && r <= 100 && bl <= 100) return b[23:0];
    return f[23:0];
  endfunction

  task automatic push_pair(input logic [127:0] b, input logic [127:0] f);
    bg_mem[bg_wr % 256] = b;
    fg_mem[fg_wr % 256] = f;
    bg_wr++;
    fg_wr++;
    for (int i = 0; i < 4; i++) exp_q.push_back(model_px(b[i*32 +: 32], f[i*32 +: 32]));
  endtask

  function automatic logic [31:0] rand_fg_lane();
    int r, g, b;
    if ($urandom % 2) begin
      r = $urandom_range(0, 110);
      g = $urandom_range(140, 255);
      b = $urandom_range(0, 110);
    end else begin
      r = $urandom_range(0, 255);
      g = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
    end
    return {8'h00, 8'(r), 8'(g), 8'(b)};
  endfunction

  task automatic push_random();
    logic [127:0] b, f;
    for (int i = 0; i < 4; i++) begin
      b[i*32 +: 32] = {8'h00, 24'($urandom)};
      f[i*32 +: 32] = rand_fg_lane();
    end
    push_pair(b, f);
  endtask

  task automatic wait_pixels(input int target, input string tag);
    int n = 0;
    while (pix_cnt < target && n < 2000) begin
      @(negedge clockgoing_pin);
      n++;
    end
    check(tag, 32'(pix_cnt >= target), 1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!video_valid && n < 50) begin
      @(negedge clockgoing_pin);
      n++;
    end
    check(tag, video_valid, 1);
  endtask

  // Accepted-pixel monitor: composite value, raster markers and strobe rules.
  always @(negedge clockgoing_pin) begin
    if (aresetn) begin
      if (video_valid && video_ready) begin
        if (exp_q.size() == 0) check("pixel_extra", 1, 0);
        else check("video", video, exp_q.pop_front());
        check("frame_start", frame_start, 32'((pix_cnt % (W * H)) == 0));
        check("line_end", line_end, 32'((pix_cnt % W) == W - 1));
        pix_cnt <= pix_cnt + 1;
      end
      if (!video_valid) check("marker_idle", {frame_start, line_end}, 0);
      if (bg_rd_en || fg_rd_en) begin
        check("rd_pair", bg_rd_en, fg_rd_en);
        check("rd_single_cycle", prev_rd, 0);
      end
      prev_rd <= bg_rd_en | fg_rd_en;
    end
  end

  initial begin
    aresetn     = 1'b0;
    enable      = 1'b1;
    video_ready = 1'b1;
    push_pair({4{32'h00AABBCC}}, {4{32'h00102030}});
    push_pair({4{32'h00AABBCC}}, {4{32'h00102030}});

    // Reset with FIFOs full and enable high
    repeat (2) @(posedge clockgoing_pin);
    @(negedge clockgoing_pin);
    check("rst_video", video, 0);
    check("rst_valid", video_valid, 0);
    check("rst_bg_rd", bg_rd_en, 0);
    check("rst_fg_rd", fg_rd_en, 0);
    check("rst_markers", {frame_start, line_end}, 0);
    check("rst_skew", skew_cnt, 0);
    check("rst_state", state, 0);
    @(posedge clockgoing_pin);
    #1 aresetn = 1'b1;

    @(negedge clockgoing_pin);
    check("idle_rd", bg_rd_en, 0);
    @(negedge clockgoing_pin);
    check("fetch_rd", {bg_rd_en, fg_rd_en}, 2'b11);
    check("fetch_state", state, 1);
    @(negedge clockgoing_pin);
    check("load_rd", {bg_rd_en, fg_rd_en}, 0);
    check("load_state", state, 2);

    // Back-to-back groups: 4 valid, 3 idle, then the next group
    for (int i = 0; i < 4; i++) begin
      @(negedge clockgoing_pin);
      check("group_valid", video_valid, 1);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clockgoing_pin);
      check("group_gap", video_valid, 0);
    end
    @(negedge clockgoing_pin);
    check("second_group", video_valid, 1);
    wait_pixels(8, "t2_done");

    // Mixed key, including G at exactly the threshold and R just above the limit
    push_pair({32'h00444444, 32'h00333333, 32'h00222222, 32'h00111111},
              {32'h00209510, 32'h00209610, 32'h0065C810, 32'h0020C810});
    wait_pixels(12, "t3_done");

    // Backpressure on lane 1
    @(posedge clockgoing_pin);
    #1 video_ready = 1'b0;
    push_random();
    wait_valid("bp_first_valid");
    @(posedge clockgoing_pin);
    #1 video_ready = 1'b1;
    @(posedge clockgoing_pin);
    #1 video_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clockgoing_pin);
      check("bp_valid", video_valid, 1);
      check("bp_video", video, exp_q[0]);
      check("bp_frame_start", frame_start, 32'((pix_cnt % (W * H)) == 0));
      check("bp_line_end", line_end, 32'((pix_cnt % W) == W - 1));
    end
    @(posedge clockgoing_pin);
    #1 video_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clockgoing_pin);
      check("bp_drain", video_valid, 1);
    end
    wait_pixels(16, "t4_done");

    // Enable dropped mid-group: the group completes, nothing further is read
    push_random();
    push_random();
    wait_valid("en_group_valid");
    @(posedge clockgoing_pin);
    #1 enable = 1'b0;
    wait_pixels(20, "en_group_done");
    repeat (10) @(negedge clockgoing_pin);
    check("en_hold_pix", pix_cnt, 20);
    check("en_hold_rd", bg_rd, 5);
    @(posedge clockgoing_pin);
    #1 enable = 1'b1;
    wait_pixels(24, "en_resume");

    // Randomized groups with random backpressure
    for (int g = 0; g < 6; g++) push_random();
    begin
      int n = 0;
      while (pix_cnt < 48 && n < 2000) begin
        @(posedge clockgoing_pin);
        #1 video_ready = ($urandom % 4) != 0;
        n++;
      end
    end
    video_ready = 1'b1;
    check("random_done", 32'(pix_cnt >= 48), 1);

    // Both FIFOs empty: silent stall
    repeat (10) @(negedge clockgoing_pin);
    check("both_empty_skew", skew_cnt, 0);
    check("both_empty_rd", bg_rd, 12);
    check("exp_drained", exp_q.size(), 0);

    // Skew: bg has data, fg empty
    @(posedge clockgoing_pin);
    #1 enable = 1'b0;
    bg_mem[bg_wr % 256] = 128'h1;
    bg_wr++;
    @(posedge clockgoing_pin);
    #1 enable = 1'b1;
    repeat (10) @(posedge clockgoing_pin);
    #1 enable = 1'b0;
    @(negedge clockgoing_pin);
    check("skew_10", skew_cnt, 10);
    check("skew_no_rd", bg_rd, 12);
    check("skew_state", state, 0);

    enable = 1'b1;
    repeat (65524) @(posedge clockgoing_pin);
    #1 enable = 1'b0;
    @(negedge clockgoing_pin);
    check("skew_fffe", skew_cnt, 16'hFFFE);
    enable = 1'b1;
    repeat (5) @(posedge clockgoing_pin);
    #1 enable = 1'b0;
    @(negedge clockgoing_pin);
    check("skew_sat", skew_cnt, 16'hFFFF);
    check("skew_sat_no_rd", bg_rd, 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
